// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch
//   Instruction prefetcher. Issues sequential word fetches to instruction
//   memory, buffers returned words in a DEPTH-entry queue and presents the
//   oldest one to the core. A redirect flushes the queue, restarts fetching at
//   the new address and drops responses still in flight for the old path.
//
// Parameters
//   DEPTH     queue entries (power of two, 2..16)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, reset                         clock, async active-high reset
//   mem_req_valid/addr/ready           fetch request channel
//   mem_rsp_valid/data                 in-order response channel
//   inst_valid/data/pc, inst_ready     instruction channel to the core
//   redirect_valid, redirect_pc        taken branch/jump, flush and refetch
module ifetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;        // address of the oldest non-discarded request
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] outstanding_nxt;
  logic [CW:0]   credit_sum;
  logic [31:0]   redirect_tgt;
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  logic          unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Every queue slot is either filled or reserved by an in-flight request,
  // so a response can never find the queue full.
  assign credit_sum    = {1'b0, occ} + {1'b0, outstanding};
  assign mem_req_valid = !reset && !redirect_valid && (credit_sum < DEPTH_C);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Stray responses with nothing outstanding (e.g. from before a reset) are ignored.
  assign rsp_fire = mem_rsp_valid && (outstanding != '0);
  assign push     = rsp_fire && (discard == '0) && !redirect_valid;

  assign inst_valid = (occ != '0);
  assign inst_data  = q_data[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    outstanding_nxt = outstanding;
    case ({req_fire, rsp_fire})
      2'b10:   outstanding_nxt = outstanding + CW'(1);
      2'b01:   outstanding_nxt = outstanding - CW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        occ      <= '0;
        discard  <= outstanding_nxt;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_fire && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   occ <= occ + CW'(1);
          2'b01:   occ <= occ - CW'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= rsp_pc;
      q_data[wr_ptr] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
module tb_ifetch_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  logic [31:0] acc_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          cyc = 0;
  int          lat = 1;
  bit          toggle_rdy = 1'b0;
  bit          stale_rsp = 1'b0;
  bit          model_rsp = 1'b0;
  int          stall_err = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model and monitor: drive at the falling edge, sample just before
  // the rising edge once all inputs and combinational outputs have settled.
  always begin
    @(negedge clk);
    if (stale_rsp) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
      model_rsp     = 1'b0;
      stale_rsp     = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mq[0].addr;
      model_rsp     = 1'b1;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
      model_rsp     = 1'b0;
    end
    if (toggle_rdy) mem_req_ready = ~mem_req_ready;
    else            mem_req_ready = 1'b1;
    #4;
    if (reset) begin
      mq.delete();
      prev_stall = 1'b0;
    end else begin
      if (mem_rsp_valid && model_rsp) void'(mq.pop_front());
      if (mem_req_valid && mem_req_ready) begin
        mq.push_back('{addr: mem_req_addr, due: cyc + lat});
        acc_q.push_back(mem_req_addr);
      end
      if (prev_stall && mem_req_valid && (mem_req_addr != prev_addr)) stall_err++;
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;
      if (inst_valid && inst_ready) begin
        got_pc.push_back(inst_pc);
        got_data.push_back(inst_data);
        got_cyc.push_back(cyc);
      end
    end
    cyc++;
  end

  task automatic clear_logs();
    acc_q.delete();
    got_pc.delete();
    got_data.delete();
    got_cyc.delete();
    stall_err = 0;
  endtask

  task automatic do_reset(input int latency, input logic rdy);
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    toggle_rdy     = 1'b0;
    lat            = latency;
    inst_ready     = rdy;
    @(negedge clk);
    clear_logs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    reset          = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;

    // Reset state
    @(negedge clk); #1;
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_req_addr", mem_req_addr, 32'h0);

    // Streaming, 1-cycle memory, first request right after reset release
    do_reset(1, 1'b1);
    #1;
    check("first_req_valid", mem_req_valid, 1'b1);
    check("first_req_addr", mem_req_addr, 32'h0);
    repeat (12) @(negedge clk);
    check("stream_count_ge8", 32'(got_pc.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stream_pc%0d", i), got_pc[i], 32'(i * 4));
      check($sformatf("stream_data%0d", i), got_data[i], 32'(i * 4));
    end
    for (int i = 0; i < 7; i++)
      check($sformatf("stream_rate%0d", i), 32'(got_cyc[i+1] - got_cyc[i]), 32'd1);

    // Core stalled: credits stop issue at DEPTH requests
    do_reset(1, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    check("stall_req_count", 32'(acc_q.size()), 32'd4);
    check("stall_req_valid", mem_req_valid, 1'b0);
    check("stall_inst_valid", inst_valid, 1'b1);
    check("stall_inst_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++)
      check($sformatf("stall_order%0d", i), got_pc[i], 32'(i * 4));

    // Memory backpressure 1010...
    do_reset(1, 1'b1);
    toggle_rdy = 1'b1;
    repeat (40) @(negedge clk);
    toggle_rdy = 1'b0;
    check("bp_addr_stable", 32'(stall_err), 32'd0);
    check("bp_acc_count_ge15", 32'(acc_q.size() >= 15), 32'd1);
    check("bp_acc_first", acc_q[0], 32'h0);
    bad = 0;
    for (int i = 1; i < acc_q.size(); i++)
      if (acc_q[i] != acc_q[i-1] + 32'd4) bad++;
    check("bp_acc_seq", 32'(bad), 32'd0);
    check("bp_got_count_ge15", 32'(got_pc.size() >= 15), 32'd1);
    bad = 0;
    for (int i = 0; i < got_pc.size(); i++)
      if (got_pc[i] != 32'(i * 4) || got_data[i] != 32'(i * 4)) bad++;
    check("bp_got_seq", 32'(bad), 32'd0);

    // 3-cycle memory, redirect with three requests in flight
    do_reset(3, 1'b1);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check("rd3_inflight", 32'(mq.size()), 32'd3);
    check("rd3_req_blocked", mem_req_valid, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("rd3_inst_flushed", inst_valid, 1'b0);
    check("rd3_req_addr", mem_req_addr, 32'h0000_0100);
    repeat (15) @(negedge clk);
    check("rd3_pc0", got_pc[0], 32'h0000_0100);
    check("rd3_data0", got_data[0], 32'h0000_0100);
    check("rd3_pc1", got_pc[1], 32'h0000_0104);
    check("rd3_pc2", got_pc[2], 32'h0000_0108);

    // Redirect together with a response and an inst handshake
    do_reset(1, 1'b1);
    repeat (6) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    check("rdx_pre_rsp", mem_rsp_valid, 1'b1);
    check("rdx_pre_inst", inst_valid, 1'b1);
    @(negedge clk);
    redirect_valid = 1'b0;
    clear_logs();
    #1;
    check("rdx_inst_flushed", inst_valid, 1'b0);
    repeat (6) @(negedge clk);
    check("rdx_pc0", got_pc[0], 32'h0000_0200);
    check("rdx_data0", got_data[0], 32'h0000_0200);
    check("rdx_pc1", got_pc[1], 32'h0000_0204);

    // Back-to-back redirects, low bits ignored, address wrap
    do_reset(1, 1'b1);
    repeat (5) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    clear_logs();
    #1;
    check("wrap_req_valid", mem_req_valid, 1'b1);
    check("wrap_req_addr0", mem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap_req_addr1", mem_req_addr, 32'h0000_0000);
    repeat (6) @(negedge clk);
    check("wrap_pc0", got_pc[0], 32'hFFFF_FFFC);
    check("wrap_pc1", got_pc[1], 32'h0000_0000);
    check("wrap_data1", got_data[1], 32'h0000_0000);

    // Reset mid-operation, stale response after release is ignored
    do_reset(3, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    check("mid_pre_inst_valid", inst_valid, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_req_valid", mem_req_valid, 1'b0);
    check("mid_rst_inst_valid", inst_valid, 1'b0);
    inst_ready = 1'b1;
    @(negedge clk);
    clear_logs();
    #1;
    stale_rsp = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_pc0", got_pc[0], 32'h0);
    check("mid_data0", got_data[0], 32'h0);
    check("mid_pc1", got_pc[1], 32'h4);
    check("mid_data1", got_data[1], 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
